mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multicycle MIPS main controller. It is the sequential stage directly upstream of the datapath 2:1 and 4:1 operand/PC/writeback multiplexers, and it produces all of their select lines.
- A Moore FSM generates per-state mux selects and register/memory write enables.
- A combinational ALU decoder maps ALUOp and funct to ALU control.
- A memory-ready handshake stretches the fetch and memory states.

Parameters:
- MEM_WAIT_EN, 1: 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26] from IR
- funct  input  6  instr[5:0] from IR
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the access this cycle
- iord  output  1  address mux sel: 0 = PC, 1 = ALUOut
- alusrca  output  1  srcA mux sel: 0 = PC, 1 = A
- alusrcb  output  2  srcB mux sel: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  PC mux sel: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- memtoreg  output  1  WD3 mux sel: 0 = ALUOut, 1 = Data
- regdst  output  1  A3 mux sel (5-bit): 0 = rt, 1 = rd
- alucontrol  output  3  ALU function
- irwrite  output  1  IR load enable
- memwrite  output  1  memory write strobe
- regwrite  output  1  register file write enable
- pcen  output  1  PC load enable
- illegal_op  output  1  one-cycle pulse on an undecodable opcode

Behaviour:
- State register updates on rising clk.
- reset=1 at an edge forces state = FETCH, including mid-instruction. While reset is high, irwrite, memwrite, regwrite, pcen and illegal_op are all 0.
- After reset deasserts, the first cycle is FETCH.
- Outputs are decoded from the current state only, except:
  - pcen = pcwrite | (branch & zero)
  - gating by rdy, where rdy = mem_ready | ~MEM_WAIT_EN
- Unlisted outputs in each state are 0.
- States and transitions:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=rdy, pcwrite=rdy. Go to DECODE if rdy, else stay.
  - DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target computed into ALUOut). Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - other -> FETCH, with illegal_op=1 for this cycle
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord=1. Go to MEMWB if rdy, else stay.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Go to FETCH.
  - MEMWR: iord=1, memwrite=1 held while waiting. Go to FETCH if rdy, else stay.
  - EXEC: alusrca=1, alusrcb=00, aluop=10. Go to ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1. Go to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Go to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Go to FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Go to FETCH.
- Latency with mem_ready=1, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each wait cycle adds one.
- ALU decoder:
  - aluop 00 -> 010 (add)
  - aluop 01 -> 110 (sub)
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; other funct -> 010, no illegal flag
  - aluop 11 -> 010
- The FSM state encoding must be one-hot or binary with no unreachable lockup: any unused encoding transitions to FETCH on the next edge.
- Simultaneous events: reset wins over mem_ready. zero is sampled only in BRANCH.

Test Plan:
- Reset 2 cycles mid-MEMRD, then release -> first cycle FETCH; during reset pcen=irwrite=regwrite=memwrite=0; alusrcb=01 and irwrite=pcen=1 in the FETCH cycle.
- lw (opcode 100011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMWB has regwrite=1, memtoreg=1, regdst=0. Total 5 cycles.
- R-type funct 101010 -> alucontrol=111 in EXEC. ALUWB has regwrite=1, regdst=1. Next is FETCH after 4 cycles.
- beq: run with zero=1, then repeat with zero=0. zero=1 -> pcen=1 and pcsrc=01 in BRANCH. zero=0 -> pcen=0. Both return to FETCH.
- sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 held 4 cycles. FETCH follows the rdy cycle. FETCH with mem_ready=0 -> irwrite=pcen=0, state held.
- Opcode 111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH, with no write enable asserted. Opcode 000010 -> JUMP: pcsrc=10, pcen=1.

Source files
------------

// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if
// Bundle of the signals exchanged between the multicycle MIPS main
// controller and its datapath.
//   master : controller side. It receives the IR fields, the ALU zero flag
//            and mem_ready, and it drives every mux select and write enable.
//   slave  : datapath side. It is the mirror image of master.
// Signals:
//   opcode[5:0], funct[5:0]  instruction fields taken from the IR
//   zero                     ALU zero flag
//   mem_ready                memory finishes its access in this cycle
//   iord, alusrca, alusrcb[1:0], pcsrc[1:0], memtoreg, regdst
//                            datapath mux selects
//   alucontrol[2:0]          ALU function
//   irwrite, memwrite, regwrite, pcen
//                            write / load enables
//   illegal_op               pulse on an undecodable opcode
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       memtoreg;
  logic       regdst;
  logic [2:0] alucontrol;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       pcen;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output iord, alusrca, alusrcb, pcsrc, memtoreg, regdst, alucontrol,
           irwrite, memwrite, regwrite, pcen, illegal_op
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  iord, alusrca, alusrcb, pcsrc, memtoreg, regdst, alucontrol,
           irwrite, memwrite, regwrite, pcen, illegal_op
  );
endinterface

// File: rtl/mips_mc_control.sv
// mips_mc_control
// Main controller for a multicycle MIPS datapath. A Moore FSM sequences
// each instruction through fetch, decode, execute, memory and writeback.
// It drives the datapath mux selects and write enables. A combinational ALU
// decoder turns aluop and funct into alucontrol. When MEM_WAIT_EN is set,
// the FETCH, MEMRD and MEMWR states stay put until mem_ready goes high.
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high. It forces FETCH and holds every write
//          enable at 0 while it is high.
//   bus    mips_mc_control_if.master (IR fields, zero and mem_ready in;
//          selects, enables and illegal_op out)
module mips_mc_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mips_mc_control_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Binary encoding. The four unused codes fall into the default arm and
  // recover to FETCH.
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  // Per-state Moore controls. Gating by rdy, zero and reset happens after
  // the register, outside this struct.
  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       memtoreg;
    logic       regdst;
    logic       fetch;
    logic       pcwrite;
    logic       memwrite;
    logic       regwrite;
    logic       branch;
  } ctl_t;

  state_t state;
  state_t next_state;
  ctl_t   ctl;
  logic   rdy;
  logic   op_legal;

  assign rdy = bus.mem_ready | ~MEM_WAIT_EN;

  // Opcodes the DECODE state knows how to dispatch.
  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  // Control pattern for each state. Any field not set here is 0.
  function automatic ctl_t decode_state(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.fetch   = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:  c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB: c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic. Memory states stall on rdy. DECODE dispatches on the
  // opcode. MEMADR picks the store path only on an sw opcode.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = rdy ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: next_state = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  next_state = rdy ? MEMWB : MEMRD;
      MEMWB:  next_state = FETCH;
      MEMWR:  next_state = rdy ? FETCH : MEMWR;
      EXEC:   next_state = ALUWB;
      ALUWB:  next_state = FETCH;
      BRANCH: next_state = FETCH;
      ADDIEX: next_state = ADDIWB;
      ADDIWB: next_state = FETCH;
      JUMP:   next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // State register. The Moore controls are registered from the decode of
  // the incoming state, so they always line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctl   <= decode_state(FETCH);
    end else begin
      state <= next_state;
      ctl   <= decode_state(next_state);
    end
  end

  // ALU decoder. An unknown funct falls back to add and is not flagged.
  always_comb begin
    bus.alucontrol = 3'b010;
    case (ctl.aluop)
      2'b00: bus.alucontrol = 3'b010;
      2'b01: bus.alucontrol = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100000: bus.alucontrol = 3'b010;
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          default:   bus.alucontrol = 3'b010;
        endcase
      end
      default: bus.alucontrol = 3'b010;
    endcase
  end

  // Mux selects come straight from the registered Moore controls.
  assign bus.iord     = ctl.iord;
  assign bus.alusrca  = ctl.alusrca;
  assign bus.alusrcb  = ctl.alusrcb;
  assign bus.pcsrc    = ctl.pcsrc;
  assign bus.memtoreg = ctl.memtoreg;
  assign bus.regdst   = ctl.regdst;

  // Write enables are forced low for the whole reset cycle, including the
  // first one, when the state register still shows the interrupted state.
  // The fetch-side strobes wait for rdy. The jump PC write does not.
  assign bus.irwrite    = ~reset & ctl.fetch & rdy;
  assign bus.pcen       = ~reset & ((ctl.pcwrite & (rdy | ~ctl.fetch)) |
                                    (ctl.branch & bus.zero));
  assign bus.memwrite   = ~reset & ctl.memwrite;
  assign bus.regwrite   = ~reset & ctl.regwrite;
  assign bus.illegal_op = ~reset & (state == DECODE) & ~op_legal;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control
// Directed test of mips_mc_control. Each stimulus cycle drives the inputs
// and pushes the hand-derived expected output vector for that cycle into a
// queue. A monitor running on the falling edge pops each entry and compares
// it with the DUT outputs.
module tb_mips_mc_control;

  typedef enum {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } tst_e;

  // Vector layout: {iord, alusrca, alusrcb[1:0], pcsrc[1:0], memtoreg,
  // regdst, alucontrol[2:0], irwrite, memwrite, regwrite, pcen, illegal_op}
  typedef struct {
    string       name;
    logic [15:0] vec;
    logic [15:0] mask;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   step;
  exp_t sb[$];

  mips_mc_control_if bus ();

  mips_mc_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle spent in state st.
  function automatic logic [15:0] expVec(tst_e st, bit rdy, bit z, bit ill,
                                         logic [2:0] alu);
    logic       iord, asa, mtr, rdst, irw, mw, rw, pen;
    logic [1:0] asb, psrc;
    logic [2:0] ac;
    iord = 0; asa = 0; mtr = 0; rdst = 0; irw = 0; mw = 0; rw = 0; pen = 0;
    asb = 2'b00; psrc = 2'b00; ac = 3'b010;
    case (st)
      S_FETCH:  begin asb = 2'b01; irw = rdy; pen = rdy; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  iord = 1;
      S_MEMWB:  begin mtr = 1; rw = 1; end
      S_MEMWR:  begin iord = 1; mw = 1; end
      S_EXEC:   begin asa = 1; ac = alu; end
      S_ALUWB:  begin rdst = 1; rw = 1; end
      S_BRANCH: begin asa = 1; psrc = 2'b01; ac = 3'b110; pen = z; end
      S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_ADDIWB: rw = 1;
      S_JUMP:   begin psrc = 2'b10; pen = 1; end
      default:  ;
    endcase
    return {iord, asa, asb, psrc, mtr, rdst, ac, irw, mw, rw, pen, ill};
  endfunction

  // Drive one cycle of inputs and queue what the DUT should show. During
  // reset only the write enables and illegal_op are checked (all 0).
  task automatic applyStimulus(input tst_e st, input logic [5:0] op,
                               input logic [5:0] fn, input bit z,
                               input bit mr, input bit rst, input bit ill,
                               input logic [2:0] alu);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = mr;
    step++;
    e.name = $sformatf("step%0d_%s%s", step, st.name(), rst ? "_rst" : "");
    if (rst) begin
      e.vec  = 16'h0000;
      e.mask = 16'h001F;
    end else begin
      e.vec  = expVec(st, mr, z, ill, alu);
      e.mask = 16'hFFFF;
    end
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [15:0] act;
    act = {bus.iord, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.memtoreg,
           bus.regdst, bus.alucontrol, bus.irwrite, bus.memwrite,
           bus.regwrite, bus.pcen, bus.illegal_op};
    checks++;
    if ((act & e.mask) !== (e.vec & e.mask)) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (mask %b)", e.name,
               act, e.vec, e.mask);
    end
  endtask

  // Monitor: one scoreboard entry is consumed per cycle, mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111, NF = 6'b000000;

  initial begin
    logic [5:0] fns  [6];
    logic [2:0] alus [6];
    fns  = '{6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000111};
    alus = '{3'b111,    3'b010,    3'b110,    3'b000,    3'b001,    3'b010};
    checks = 0;
    errors = 0;
    step   = 0;
    reset  = 1'b1;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    // Power-on reset: two cycles with the enables held low
    applyStimulus(S_FETCH, LW, NF, 0, 1, 1, 0, 3'b010);
    applyStimulus(S_FETCH, LW, NF, 0, 1, 1, 0, 3'b010);

    // lw, with one MEMRD wait cycle
    applyStimulus(S_FETCH,  LW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_DECODE, LW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_MEMADR, LW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_MEMRD,  LW, NF, 0, 0, 0, 0, 3'b010);
    applyStimulus(S_MEMRD,  LW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_MEMWB,  LW, NF, 0, 1, 0, 0, 3'b010);

    // R-type ALU decode across the funct table, including an unknown funct
    for (int i = 0; i < 6; i++) begin
      applyStimulus(S_FETCH,  RT, fns[i], 0, 1, 0, 0, 3'b010);
      applyStimulus(S_DECODE, RT, fns[i], 0, 1, 0, 0, 3'b010);
      applyStimulus(S_EXEC,   RT, fns[i], 0, 1, 0, 0, alus[i]);
      applyStimulus(S_ALUWB,  RT, fns[i], 0, 1, 0, 0, 3'b010);
    end

    // beq taken, then not taken. zero is high outside BRANCH and must be ignored there.
    applyStimulus(S_FETCH,  BEQ, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_DECODE, BEQ, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_BRANCH, BEQ, NF, 1, 1, 0, 0, 3'b010);
    applyStimulus(S_FETCH,  BEQ, NF, 1, 1, 0, 0, 3'b010);
    applyStimulus(S_DECODE, BEQ, NF, 1, 1, 0, 0, 3'b010);
    applyStimulus(S_BRANCH, BEQ, NF, 0, 1, 0, 0, 3'b010);

    // sw with three MEMWR wait cycles, then a FETCH that stalls twice
    applyStimulus(S_FETCH,  SW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_DECODE, SW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_MEMADR, SW, NF, 0, 1, 0, 0, 3'b010);
    for (int i = 0; i < 3; i++)
      applyStimulus(S_MEMWR, SW, NF, 0, 0, 0, 0, 3'b010);
    applyStimulus(S_MEMWR,  SW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_FETCH,  SW, NF, 0, 0, 0, 0, 3'b010);
    applyStimulus(S_FETCH,  SW, NF, 0, 0, 0, 0, 3'b010);

    // Illegal opcode: a one-cycle pulse in DECODE, then back to FETCH
    applyStimulus(S_FETCH,  BAD, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_DECODE, BAD, NF, 0, 1, 0, 1, 3'b010);

    // addi
    applyStimulus(S_FETCH,  ADDI, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_DECODE, ADDI, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_ADDIEX, ADDI, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_ADDIWB, ADDI, NF, 0, 1, 0, 0, 3'b010);

    // j
    applyStimulus(S_FETCH,  JMP, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_DECODE, JMP, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_JUMP,   JMP, NF, 0, 1, 0, 0, 3'b010);

    // Reset for two cycles mid-MEMRD. Reset wins over mem_ready.
    applyStimulus(S_FETCH,  LW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_DECODE, LW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_MEMADR, LW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_MEMRD,  LW, NF, 0, 0, 0, 0, 3'b010);
    applyStimulus(S_MEMRD,  LW, NF, 0, 1, 1, 0, 3'b010);
    applyStimulus(S_FETCH,  LW, NF, 0, 1, 1, 0, 3'b010);
    applyStimulus(S_FETCH,  LW, NF, 0, 1, 0, 0, 3'b010);
    applyStimulus(S_DECODE, LW, NF, 0, 1, 0, 0, 3'b010);

    // Let the monitor drain the queue, with a bound on the wait
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
